// File: rtl/psg_pkg.sv
// Shared constants for the SN76489-style PSG: register addresses ({channel, type})
// and field widths, plus the tone-nibble merge helper.
package psg_pkg;

    localparam int TONE_BITS  = 10;
    localparam int VOL_BITS   = 4;
    localparam int NOISE_BITS = 3;

    localparam logic [2:0] TONE0 = 3'b000;
    localparam logic [2:0] VOL0  = 3'b001;
    localparam logic [2:0] TONE1 = 3'b010;
    localparam logic [2:0] VOL1  = 3'b011;
    localparam logic [2:0] TONE2 = 3'b100;
    localparam logic [2:0] VOL2  = 3'b101;
    localparam logic [2:0] NOISE = 3'b110;
    localparam logic [2:0] VOL3  = 3'b111;

    // Latch bytes carry the low nibble, data bytes carry the upper six bits.
    function automatic logic [TONE_BITS-1:0] tone_merge(input logic [TONE_BITS-1:0] cur,
                                                        input logic [7:0]           d);
        if (d[7])
            tone_merge = {cur[TONE_BITS-1:4], d[3:0]};
        else
            tone_merge = {d[5:0], cur[3:0]};
    endfunction

endpackage

// File: rtl/psg_register_bank_clock_prescaler.sv
// Free-running divider: counts 0..PRESCALE-1 and flags the terminal count as a
// one-cycle strobe.
module clock_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_strobe
);
    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (r_count == LAST)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    assign o_strobe = (r_count == LAST);

endmodule

// File: rtl/psg_register_bank.sv
// SN76489 command-byte decoder and register bank. Define PSG_PRESCALER_EN to derive
// strobe from the internal clock_prescaler; otherwise strobe is held high after reset.
module psg_register_bank
    import psg_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [7:0]            data,
    output logic [TONE_BITS-1:0]  tone0,
    output logic [TONE_BITS-1:0]  tone1,
    output logic [TONE_BITS-1:0]  tone2,
    output logic [VOL_BITS-1:0]   vol0,
    output logic [VOL_BITS-1:0]   vol1,
    output logic [VOL_BITS-1:0]   vol2,
    output logic [VOL_BITS-1:0]   vol3,
    output logic [NOISE_BITS-1:0] noise_ctrl,
    output logic                  noise_reset,
    output logic                  strobe
);
    logic [2:0]            r_addr;
    logic [TONE_BITS-1:0]  r_tone0, r_tone1, r_tone2;
    logic [VOL_BITS-1:0]   r_vol0, r_vol1, r_vol2, r_vol3;
    logic [NOISE_BITS-1:0] r_noise_ctrl;
    logic                  r_noise_reset;
    logic [2:0]            w_addr;

    // A latch byte addresses itself; a data byte reuses the last latched address.
    assign w_addr = data[7] ? data[6:4] : r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr        <= TONE0;
            r_tone0       <= '0;
            r_tone1       <= '0;
            r_tone2       <= '0;
            r_vol0        <= '1;
            r_vol1        <= '1;
            r_vol2        <= '1;
            r_vol3        <= '1;
            r_noise_ctrl  <= '0;
            r_noise_reset <= 1'b0;
        end else begin
            r_noise_reset <= 1'b0;
            if (wr) begin
                if (data[7])
                    r_addr <= data[6:4];
                case (w_addr)
                    TONE0: r_tone0 <= tone_merge(r_tone0, data);
                    TONE1: r_tone1 <= tone_merge(r_tone1, data);
                    TONE2: r_tone2 <= tone_merge(r_tone2, data);
                    VOL0:  r_vol0  <= data[3:0];
                    VOL1:  r_vol1  <= data[3:0];
                    VOL2:  r_vol2  <= data[3:0];
                    VOL3:  r_vol3  <= data[3:0];
                    NOISE: begin
                        r_noise_ctrl  <= data[2:0];
                        r_noise_reset <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PSG_PRESCALER_EN
    clock_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .o_strobe (strobe)
    );
`else
    logic r_strobe;
    logic w_unused_prescale;

    assign w_unused_prescale = (PRESCALE > 1);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_strobe <= 1'b0;
        else
            r_strobe <= 1'b1;
    end

    assign strobe = r_strobe;
`endif

    assign tone0       = r_tone0;
    assign tone1       = r_tone1;
    assign tone2       = r_tone2;
    assign vol0        = r_vol0;
    assign vol1        = r_vol1;
    assign vol2        = r_vol2;
    assign vol3        = r_vol3;
    assign noise_ctrl  = r_noise_ctrl;
    assign noise_reset = r_noise_reset;

endmodule

// File: tb/tb_psg_register_bank.sv
// Scoreboard bench for psg_register_bank: each driven cycle pushes the expected
// register state, which is popped and compared one cycle later.
module tb_psg_register_bank;
    localparam int PRESCALE = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] data = 8'h00;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] vol0, vol1, vol2, vol3;
    logic [2:0] noise_ctrl;
    logic       noise_reset;
    logic       strobe;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [9:0] t0, t1, t2;
        logic [3:0] v0, v1, v2, v3;
        logic [2:0] nc;
        logic       nr;
        logic       st;
    } exp_t;

    exp_t sb_q[$];

    logic [9:0] m_tone[3];
    logic [3:0] m_vol[4];
    logic [2:0] m_addr, m_nc;
    logic       m_nr, m_st;
    int         m_cnt;
    int         rel_cyc;
    int         strobe_hits[$];

    psg_register_bank #(.PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .data        (data),
        .tone0       (tone0),
        .tone1       (tone1),
        .tone2       (tone2),
        .vol0        (vol0),
        .vol1        (vol1),
        .vol2        (vol2),
        .vol3        (vol3),
        .noise_ctrl  (noise_ctrl),
        .noise_reset (noise_reset),
        .strobe      (strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge given the inputs in effect.
    task automatic model_edge(input logic r_n, input logic w, input logic [7:0] d);
        logic [2:0] a;
        int         i;
        if (!r_n) begin
            for (int k = 0; k < 3; k++) m_tone[k] = 10'h000;
            for (int k = 0; k < 4; k++) m_vol[k] = 4'hF;
            m_addr = 3'd0;
            m_nc   = 3'd0;
            m_nr   = 1'b0;
            m_cnt  = 0;
            m_st   = 1'b0;
        end else begin
            m_nr  = 1'b0;
            m_cnt = (m_cnt + 1) % PRESCALE;
            m_st  = 1'b1;
            if (w) begin
                a = d[7] ? d[6:4] : m_addr;
                if (d[7]) m_addr = d[6:4];
                i = int'(a[2:1]);
                if (a == 3'b110) begin
                    m_nc = d[2:0];
                    m_nr = 1'b1;
                end else if (a[0]) begin
                    m_vol[i] = d[3:0];
                end else if (d[7]) begin
                    m_tone[i][3:0] = d[3:0];
                end else begin
                    m_tone[i][9:4] = d[5:0];
                end
            end
        end
    endtask

    task automatic step(input logic r_n, input logic w, input logic [7:0] d);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst_n = r_n;
        wr    = w;
        data  = d;
        model_edge(r_n, w, d);
        e.t0 = m_tone[0]; e.t1 = m_tone[1]; e.t2 = m_tone[2];
        e.v0 = m_vol[0];  e.v1 = m_vol[1];  e.v2 = m_vol[2];  e.v3 = m_vol[3];
        e.nc = m_nc;
        e.nr = m_nr;
`ifdef PSG_PRESCALER_EN
        e.st = (!r_n) ? 1'b0 : (m_cnt == PRESCALE - 1);
`else
        e.st = m_st;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        rel_cyc = r_n ? rel_cyc + 1 : 0;
        o = sb_q.pop_front();
        chk("tone0", 32'(tone0), 32'(o.t0));
        chk("tone1", 32'(tone1), 32'(o.t1));
        chk("tone2", 32'(tone2), 32'(o.t2));
        chk("vol0", 32'(vol0), 32'(o.v0));
        chk("vol1", 32'(vol1), 32'(o.v1));
        chk("vol2", 32'(vol2), 32'(o.v2));
        chk("vol3", 32'(vol3), 32'(o.v3));
        chk("noise_ctrl", 32'(noise_ctrl), 32'(o.nc));
        chk("noise_reset", 32'(noise_reset), 32'(o.nr));
        chk("strobe", 32'(strobe), 32'(o.st));
        if (r_n && strobe) strobe_hits.push_back(rel_cyc + 1);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        step(1'b1, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'hA5);
    endtask

    initial begin
        rel_cyc = 0;
        model_edge(1'b0, 1'b0, 8'h00);

        // Reset, including a write that reset must discard.
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h9F);
        chk("reset_vol0", 32'(vol0), 32'hF);
        chk("reset_tone0", 32'(tone0), 32'h0);
        chk("reset_nreset", 32'(noise_reset), 32'h0);
        chk("reset_strobe", 32'(strobe), 32'h0);

        // Strobe cadence from reset release; rel_cyc counts edges with rst_n high.
        strobe_hits.delete();
        idle(50);
`ifdef PSG_PRESCALER_EN
        chk("strobe_hits", 32'(strobe_hits.size()), 32'd3);
        if (strobe_hits.size() == 3) begin
            chk("strobe_1st", 32'(strobe_hits[0]), 32'd16);
            chk("strobe_2nd", 32'(strobe_hits[1]), 32'd32);
            chk("strobe_3rd", 32'(strobe_hits[2]), 32'd48);
        end
`else
        chk("strobe_hits", 32'(strobe_hits.size()), 32'd50);
`endif

        // Full tone write.
        wr_byte(8'h8E);
        wr_byte(8'h0F);
        chk("tone0_full", 32'(tone0), 32'h0FE);

        // Volume latch then data rewrite.
        wr_byte(8'hB5);
        chk("vol1_latch", 32'(vol1), 32'h5);
        wr_byte(8'h0A);
        chk("vol1_data", 32'(vol1), 32'hA);
        chk("tone1_kept", 32'(tone1), 32'h000);

        // Noise latch, idle, then data byte: two pulses.
        wr_byte(8'hE5);
        chk("noise_latch", 32'(noise_ctrl), 32'h5);
        chk("noise_pulse1", 32'(noise_reset), 32'h1);
        idle(1);
        chk("noise_pulse_end", 32'(noise_reset), 32'h0);
        wr_byte(8'h03);
        chk("noise_data", 32'(noise_ctrl), 32'h3);
        chk("noise_pulse2", 32'(noise_reset), 32'h1);

        // Identical rewrites still pulse; back-to-back writes all land.
        wr_byte(8'hE3);
        wr_byte(8'hE3);
        chk("noise_rewrite", 32'(noise_reset), 32'h1);
        wr_byte(8'h90);
        wr_byte(8'hD7);
        wr_byte(8'hFC);
        wr_byte(8'hC3);
        wr_byte(8'h3F);
        chk("vol0_b2b", 32'(vol0), 32'h0);
        chk("vol2_b2b", 32'(vol2), 32'h7);
        chk("vol3_b2b", 32'(vol3), 32'hC);
        chk("tone2_b2b", 32'(tone2), 32'h3F3);

        // Zero tone passes through; wr=0 leaves everything alone.
        wr_byte(8'hA0);
        wr_byte(8'h00);
        chk("tone1_zero", 32'(tone1), 32'h000);
        idle(3);

        // Reset mid-stream with a simultaneous write, then a data byte hits tone0.
        step(1'b0, 1'b1, 8'h9F);
        chk("midrst_vol0", 32'(vol0), 32'hF);
        wr_byte(8'h3F);
        chk("midrst_tone0", 32'(tone0), 32'h3F0);
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
